// File: rtl/uartlite_axi_responder.sv
// AXI4-Lite slave exposing the UART-lite register map, with byte-stream ports in
// place of serial pins. It holds an RX FIFO, a TX FIFO and separate read and write FSMs.
module uartlite_axi_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              s_axi_aclk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [7:0]        rx_byte_data,
  input  logic              rx_byte_valid,
  output logic [7:0]        tx_byte_data,
  output logic              tx_byte_valid,
  input  logic              tx_byte_ready,
  output logic              interrupt
);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic        intr_en_q, intr_en_d;
  logic        overrun_q, overrun_d;
  logic        interrupt_q, interrupt_d;
  logic        rx_ne_prev_q, rx_ne_prev_d;
  logic        tx_empty_prev_q, tx_empty_prev_d;
  logic [7:0]  rx_mem_q [FIFO_DEPTH];
  logic [7:0]  tx_mem_q [FIFO_DEPTH];

  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        wr_en, rd_en, stat_rd;
  logic [1:0]  wr_sel, rd_sel;
  logic        rx_clear, tx_clear, rx_pop, rx_push, tx_pop, tx_push, overrun_set;
  logic [7:0]  rx_head;
  logic [31:0] rd_val;
  logic        unused_inputs;

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[IW] != rx_rptr_q[IW]) && (rx_wptr_q[IW-1:0] == rx_rptr_q[IW-1:0]);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[IW] != tx_rptr_q[IW]) && (tx_wptr_q[IW-1:0] == tx_rptr_q[IW-1:0]);
  assign rx_head  = rx_mem_q[rx_rptr_q[IW-1:0]];

  // Register side effects fire in the ACK states, while the master still holds addr/data.
  assign wr_en   = (w_state_q == W_ACK) && s_axi_wstrb[0];
  assign wr_sel  = s_axi_awaddr[3:2];
  assign rd_en   = (r_state_q == R_ACK);
  assign rd_sel  = s_axi_araddr[3:2];
  assign stat_rd = rd_en && (rd_sel == 2'd2);

  assign tx_clear    = wr_en && (wr_sel == 2'd3) && s_axi_wdata[0];
  assign rx_clear    = wr_en && (wr_sel == 2'd3) && s_axi_wdata[1];
  assign rx_pop      = rd_en && (rd_sel == 2'd0) && !rx_empty;
  assign rx_push     = rx_byte_valid && (!rx_full || rx_pop) && !rx_clear;
  assign overrun_set = rx_byte_valid && rx_full && !rx_pop && !rx_clear;
  assign tx_pop      = !tx_empty && tx_byte_ready;
  assign tx_push     = wr_en && (wr_sel == 2'd1) && (!tx_full || tx_pop) && !tx_clear;

  always_comb begin
    rd_val = 32'd0;
    case (rd_sel)
      2'd0:    rd_val = rx_empty ? 32'd0 : {24'd0, rx_head};
      2'd2:    rd_val = {26'd0, overrun_q, intr_en_q, tx_full, tx_empty, rx_full, !rx_empty};
      default: rd_val = 32'd0;
    endcase
  end

  // Handshakes: a beat transfers on the rising edge where valid and ready are both high;
  // the slave raises awready/wready together only once both AW and W are presented.
  always_comb begin
    w_state_d = w_state_q;
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    case (w_state_q)
      W_IDLE: if (s_axi_awvalid && s_axi_wvalid) begin
        w_state_d = W_ACK;
        awready_d = 1'b1;
      end
      W_ACK: begin
        w_state_d = W_RESP;
        bvalid_d  = 1'b1;
      end
      W_RESP: if (s_axi_bready) begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
      end
      default: w_state_d = W_IDLE;
    endcase

    r_state_d = r_state_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (s_axi_arvalid) begin
        r_state_d = R_ACK;
        arready_d = 1'b1;
      end
      R_ACK: begin
        r_state_d = R_DATA;
        rvalid_d  = 1'b1;
        rdata_d   = rd_val;
      end
      R_DATA: if (s_axi_rready) begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
    if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
    if (rx_clear) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
    end

    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
    if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
    if (tx_clear) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
    end

    intr_en_d = intr_en_q;
    if (wr_en && (wr_sel == 2'd3)) intr_en_d = s_axi_wdata[4];

    // A new overrun in the same cycle as a STAT read must not be lost.
    overrun_d = overrun_q;
    if (stat_rd)     overrun_d = 1'b0;
    if (overrun_set) overrun_d = 1'b1;

    rx_ne_prev_d    = !rx_empty;
    tx_empty_prev_d = tx_empty;
    interrupt_d     = intr_en_q && ((!rx_empty && !rx_ne_prev_q) || (tx_empty && !tx_empty_prev_q));
  end

  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      w_state_q       <= W_IDLE;
      r_state_q       <= R_IDLE;
      awready_q       <= 1'b0;
      bvalid_q        <= 1'b0;
      arready_q       <= 1'b0;
      rvalid_q        <= 1'b0;
      rdata_q         <= 32'd0;
      rx_wptr_q       <= '0;
      rx_rptr_q       <= '0;
      tx_wptr_q       <= '0;
      tx_rptr_q       <= '0;
      intr_en_q       <= 1'b0;
      overrun_q       <= 1'b0;
      interrupt_q     <= 1'b0;
      rx_ne_prev_q    <= 1'b0;
      tx_empty_prev_q <= 1'b1;
    end else begin
      w_state_q       <= w_state_d;
      r_state_q       <= r_state_d;
      awready_q       <= awready_d;
      bvalid_q        <= bvalid_d;
      arready_q       <= arready_d;
      rvalid_q        <= rvalid_d;
      rdata_q         <= rdata_d;
      rx_wptr_q       <= rx_wptr_d;
      rx_rptr_q       <= rx_rptr_d;
      tx_wptr_q       <= tx_wptr_d;
      tx_rptr_q       <= tx_rptr_d;
      intr_en_q       <= intr_en_d;
      overrun_q       <= overrun_d;
      interrupt_q     <= interrupt_d;
      rx_ne_prev_q    <= rx_ne_prev_d;
      tx_empty_prev_q <= tx_empty_prev_d;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (rx_push) rx_mem_q[rx_wptr_q[IW-1:0]] <= rx_byte_data;
    if (tx_push) tx_mem_q[tx_wptr_q[IW-1:0]] <= s_axi_wdata[7:0];
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign tx_byte_data  = tx_mem_q[tx_rptr_q[IW-1:0]];
  assign tx_byte_valid = !tx_empty;
  assign interrupt     = interrupt_q;

  assign unused_inputs = ^{s_axi_wdata, s_axi_wstrb, s_axi_awaddr, s_axi_araddr};
endmodule

// File: tb/tb_uartlite_axi_responder.sv
// Bench for uartlite_axi_responder: table of register write/read vectors plus
// hand-written multi-cycle sequences, with read-data and TX-byte scoreboards.
module tb_uartlite_axi_responder;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic [7:0]  rx_byte_data;
  logic        rx_byte_valid;
  logic [7:0]  tx_byte_data;
  logic        tx_byte_valid, tx_byte_ready;
  logic        interrupt;

  always #5 clk = ~clk;

  uartlite_axi_responder #(.FIFO_DEPTH(DEPTH), .ADDR_W(4)) dut (
    .s_axi_aclk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .rx_byte_data(rx_byte_data), .rx_byte_valid(rx_byte_valid),
    .tx_byte_data(tx_byte_data), .tx_byte_valid(tx_byte_valid), .tx_byte_ready(tx_byte_ready),
    .interrupt(interrupt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int intr_cnt = 0;
  int last_ar_lat = 0;
  int last_r_lat = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];

  typedef struct {
    bit          do_wr;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [3:0]  rd_addr;
    logic [31:0] rd_exp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no handshake expected one within 20 cycles", name);
  endtask

  // TX scoreboard: a byte leaves the DUT on every cycle with valid and ready high.
  always @(negedge clk) begin
    if (!rst && tx_byte_valid && tx_byte_ready) begin
      if (tx_exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_byte_data);
      end else begin
        check("tx_byte", {24'd0, tx_byte_data}, {24'd0, tx_exp_q.pop_front()});
      end
    end
    if (!rst && interrupt) intr_cnt++;
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit push_rx, input logic [7:0] rx_b, input string name);
    int waited;
    if (strb[0] && addr[3:2] == 2'd1) tx_exp_q.push_back(data[7:0]);
    if (strb[0] && addr[3:2] == 2'd3 && data[0]) tx_exp_q.delete();
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    waited = 0;
    do begin @(posedge clk); #1; waited++; end while (!s_axi_awready && waited < 20);
    if (!s_axi_awready) begin
      fail_timeout({name, "_aw"});
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      return;
    end
    check({name, "_wready"}, {31'd0, s_axi_wready}, 32'd1);
    if (push_rx) begin rx_byte_valid = 1'b1; rx_byte_data = rx_b; end
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    waited = 0;
    while (!s_axi_bvalid && waited < 20) begin @(posedge clk); #1; waited++; end
    if (!s_axi_bvalid) fail_timeout({name, "_b"});
    else check({name, "_bresp"}, {30'd0, s_axi_bresp}, 32'd0);
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp,
                          input bit push_rx, input logic [7:0] rx_b, input string name);
    int waited;
    exp_q.push_back(exp);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    waited = 0;
    do begin @(posedge clk); #1; waited++; end while (!s_axi_arready && waited < 20);
    last_ar_lat = waited;
    if (!s_axi_arready) begin
      fail_timeout({name, "_ar"});
      s_axi_arvalid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    if (push_rx) begin rx_byte_valid = 1'b1; rx_byte_data = rx_b; end
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    waited = 0;
    while (!s_axi_rvalid && waited < 20) begin @(posedge clk); #1; waited++; end
    last_r_lat = waited;
    if (!s_axi_rvalid) begin
      fail_timeout({name, "_r"});
      void'(exp_q.pop_front());
    end else begin
      check(name, s_axi_rdata, exp_q.pop_front());
    end
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got no end of test expected one before 500us");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    logic [7:0] rb;

    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; rx_byte_data = '0; rx_byte_valid = 1'b0; tx_byte_ready = 1'b0;

    vecs[0] = '{1'b0, 4'h0, 32'h00, 4'h0, 4'h8, 32'h04};
    vecs[1] = '{1'b0, 4'h0, 32'h00, 4'h0, 4'h0, 32'h00};
    vecs[2] = '{1'b0, 4'h0, 32'h00, 4'h0, 4'h4, 32'h00};
    vecs[3] = '{1'b0, 4'h0, 32'h00, 4'h0, 4'hC, 32'h00};
    vecs[4] = '{1'b1, 4'hC, 32'h10, 4'hF, 4'h8, 32'h14};
    vecs[5] = '{1'b1, 4'hC, 32'h00, 4'hE, 4'h8, 32'h14};
    vecs[6] = '{1'b1, 4'h0, 32'hFF, 4'hF, 4'h8, 32'h14};
    vecs[7] = '{1'b1, 4'h8, 32'hFF, 4'hF, 4'h8, 32'h14};
    vecs[8] = '{1'b1, 4'hC, 32'h00, 4'hF, 4'h8, 32'h04};
    vecs[9] = '{1'b1, 4'h4, 32'h55, 4'hE, 4'h8, 32'h04};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_valids", {25'd0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                           s_axi_rvalid, interrupt, tx_byte_valid}, 32'd0);
    check("reset_rdata", s_axi_rdata, 32'd0);
    check("reset_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);

    axi_read(4'h8, 32'h04, 1'b0, 8'h00, "reset_stat");
    check("ar_latency", last_ar_lat, 1);
    check("r_latency", last_r_lat, 0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_wr)
        axi_write(vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_strb, 1'b0, 8'h00,
                  $sformatf("vec%0d_wr", i));
      axi_read(vecs[i].rd_addr, vecs[i].rd_exp, 1'b0, 8'h00, $sformatf("vec%0d_rd", i));
      idle_gap();
    end
    check("intr_none_table", intr_cnt, 0);

    axi_write(4'h4, 32'h41, 4'hF, 1'b0, 8'h00, "tx_41");
    axi_write(4'h4, 32'h42, 4'hF, 1'b0, 8'h00, "tx_42");
    check("tx_valid_held", {31'd0, tx_byte_valid}, 32'd1);
    check("tx_head", {24'd0, tx_byte_data}, 32'h41);
    axi_read(4'h8, 32'h00, 1'b0, 8'h00, "stat_tx_busy");
    tx_byte_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("tx_drained_valid", {31'd0, tx_byte_valid}, 32'd0);
    check("tx_drained_count", tx_exp_q.size(), 0);
    tx_byte_ready = 1'b0;
    axi_read(4'h8, 32'h04, 1'b0, 8'h00, "stat_tx_empty");

    axi_write(4'h4, 32'h66, 4'hF, 1'b0, 8'h00, "tx_hold_66");
    for (int i = 0; i <= DEPTH; i++) begin
      rx_byte_valid = 1'b1;
      rx_byte_data = 8'(i);
      @(posedge clk); #1;
    end
    rx_byte_valid = 1'b0;
    axi_read(4'h8, 32'h23, 1'b0, 8'h00, "stat_overrun");
    axi_read(4'h8, 32'h03, 1'b0, 8'h00, "stat_overrun_cleared");
    for (int i = 0; i < DEPTH; i++)
      axi_read(4'h0, 32'(i), 1'b0, 8'h00, $sformatf("rx_rd_%0d", i));
    axi_read(4'h0, 32'h00, 1'b0, 8'h00, "rx_rd_empty");
    axi_read(4'h8, 32'h00, 1'b0, 8'h00, "stat_rx_drained");
    tx_byte_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tx_byte_ready = 1'b0;

    axi_write(4'hC, 32'h10, 4'hF, 1'b0, 8'h00, "ctrl_intr_on");
    rb = 8'($urandom_range(0, 255));
    rx_byte_valid = 1'b1; rx_byte_data = rb;
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
    @(posedge clk); #1;
    check("intr_rx_pulse", {31'd0, interrupt}, 32'd1);
    @(posedge clk); #1;
    check("intr_rx_single", {31'd0, interrupt}, 32'd0);
    check("intr_cnt_rx", intr_cnt, 1);
    axi_read(4'h0, {24'd0, rb}, 1'b0, 8'h00, "intr_rx_pop");
    axi_write(4'h4, 32'h77, 4'hF, 1'b0, 8'h00, "intr_tx_77");
    tx_byte_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tx_byte_ready = 1'b0;
    check("intr_cnt_tx", intr_cnt, 2);
    axi_write(4'hC, 32'h00, 4'hF, 1'b0, 8'h00, "ctrl_intr_off");
    rx_byte_valid = 1'b1; rx_byte_data = 8'h11;
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("intr_cnt_disabled", intr_cnt, 2);
    axi_read(4'h0, 32'h11, 1'b0, 8'h00, "intr_off_pop");

    tx_exp_q.push_back(8'h33);
    s_axi_awaddr = 4'h4; s_axi_wdata = 32'h33; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    waited = 0;
    do begin @(posedge clk); #1; waited++; end while (!s_axi_awready && waited < 20);
    check("hold_aw_first", {31'd0, s_axi_awready}, 32'd1);
    @(posedge clk); #1;
    tx_exp_q.push_back(8'h34);
    s_axi_wdata = 32'h34;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_bvalid_%0d", i), {31'd0, s_axi_bvalid}, 32'd1);
      check($sformatf("hold_no_aw_%0d", i), {31'd0, s_axi_awready}, 32'd0);
      @(posedge clk); #1;
    end
    check("hold_bvalid_end", {31'd0, s_axi_bvalid}, 32'd1);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check("hold_b_done", {31'd0, s_axi_bvalid}, 32'd0);
    @(posedge clk); #1;
    check("hold_aw_second", {31'd0, s_axi_awready}, 32'd1);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("hold_b_second", {31'd0, s_axi_bvalid}, 32'd1);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    tx_byte_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tx_byte_ready = 1'b0;

    axi_write(4'h4, 32'h99, 4'hF, 1'b0, 8'h00, "tx_hold_99");
    for (int i = 0; i < DEPTH; i++) begin
      rx_byte_valid = 1'b1;
      rx_byte_data = 8'(8'h80 + i);
      @(posedge clk); #1;
    end
    rx_byte_valid = 1'b0;
    axi_read(4'h8, 32'h03, 1'b0, 8'h00, "stat_full");
    axi_read(4'h0, 32'h80, 1'b1, 8'h90, "rx_pop_push_full");
    axi_read(4'h8, 32'h03, 1'b0, 8'h00, "stat_full_no_overrun");
    axi_write(4'hC, 32'h03, 4'hF, 1'b0, 8'h00, "ctrl_clear_both");
    axi_read(4'h8, 32'h04, 1'b0, 8'h00, "stat_cleared");
    axi_read(4'h0, 32'h00, 1'b0, 8'h00, "rx_cleared");

    axi_write(4'hC, 32'h02, 4'hF, 1'b1, 8'hAB, "ctrl_rxclr_push");
    axi_read(4'h8, 32'h04, 1'b0, 8'h00, "stat_clear_wins");

    check("exp_q_empty", exp_q.size(), 0);
    check("tx_exp_q_empty", tx_exp_q.size(), 0);
    check("intr_cnt_final", intr_cnt, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/uartlite_axi_responder.md
Name: uartlite_axi_responder

Overview:
- AXI4-Lite slave that presents the UART-lite register map (RX FIFO 0x0, TX FIFO 0x4, STAT 0x8, CTRL 0xC) to the existing AXI reader master.
- Serial pins are replaced by byte-stream ports, so the reader and inference path can be simulated and looped back in fabric without the vendor UART core.
- Contains an RX FIFO and a TX FIFO, an AXI write-channel FSM, an AXI read-channel FSM, and status/interrupt logic.

Parameters:
- FIFO_DEPTH, 16, entries per FIFO; must be a power of 2, minimum 2.
- ADDR_W, 4, AXI address width; only addr[3:2] is decoded.

Ports:
- s_axi_aclk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid  in  1;  s_axi_awready  out  1.
- s_axi_wdata  in  32;  s_axi_wstrb  in  4;  s_axi_wvalid  in  1;  s_axi_wready  out  1.
- s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1.
- s_axi_araddr  in  ADDR_W;  s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rdata  out  32;  s_axi_rresp  out  2;  s_axi_rvalid  out  1;  s_axi_rready  in  1.
- rx_byte_data  in  8  byte from link; pushed into RX FIFO.
- rx_byte_valid  in  1  one-cycle push strobe; there is no backpressure.
- tx_byte_data  out  8  head of TX FIFO.
- tx_byte_valid  out  1  TX FIFO non-empty.
- tx_byte_ready  in  1  sink accepts; pops when valid & ready.
- interrupt  out  1  one-cycle pulse.

Behaviour:
- Reset: all ready/valid outputs 0; bresp = rresp = 2'b00; rdata = 0; interrupt = 0; both FIFOs empty; intr_en = 0; overrun = 0; both FSMs idle. Reset mid-transaction abandons it with no response.
- bresp and rresp are always OKAY (2'b00).
- Write FSM:
  - W_IDLE → W_ACK when awvalid & wvalid are both high.
  - W_ACK: awready = wready = 1 for exactly one cycle; the register write executes this cycle; → W_RESP.
  - W_RESP: bvalid = 1 until bready; → W_IDLE the cycle after the handshake.
  - AW alone or W alone is never accepted.
- Write decode (only when wstrb[0] = 1; otherwise no effect, still OKAY):
  - 0x4 pushes wdata[7:0] into the TX FIFO. If TX is full the byte is dropped, with no flag.
  - 0xC CTRL: bit0 clears TX FIFO, bit1 clears RX FIFO, bit4 loads intr_en.
  - 0x0 and 0x8 are ignored.
- Read FSM:
  - R_IDLE → R_ACK when arvalid.
  - R_ACK: arready = 1 for one cycle; rdata is captured from the decode; → R_DATA.
  - R_DATA: rvalid = 1, rdata stable until rready; → R_IDLE.
  - Read and write FSMs are independent and may run concurrently.
- Read decode (upper bits of rdata are 0):
  - 0x0 returns the RX head in [7:0] and pops it in R_ACK. If RX is empty, returns 0 and does not pop.
  - 0x4 and 0xC return 0.
  - 0x8 STAT: bit0 rx non-empty, bit1 rx full, bit2 tx empty, bit3 tx full, bit4 intr_en, bit5 overrun, bits7:6 = 0. A STAT read clears overrun in R_ACK.
- RX push:
  - rx_byte_valid with RX full sets overrun and drops the byte.
  - A push and a pop in the same cycle on a full FIFO both succeed; no overrun.
  - A push and a CTRL RX clear in the same cycle: the clear wins, the byte is dropped, overrun is not set.
- TX FIFO:
  - tx_byte_data is combinational from the head.
  - An AXI push and a stream pop in the same cycle both succeed, including at full.
  - A CTRL TX clear wins over both.
- Overrun: set and STAT-read-clear in the same cycle → overrun remains set.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits with wrap-around. Full when MSBs differ and the rest are equal; empty when the pointers are equal.
- Interrupt: one-cycle pulse, registered (one cycle after the causing edge), when intr_en & (rx non-empty rises 0→1, or tx empty rises 0→1). There is no pulse for transitions that occur while intr_en = 0.

Test Plan:
- Reset, then read 0x8 → rdata = 0x04. arready is high one cycle after arvalid; rvalid the cycle after that.
- Write 0x41, 0x42 to 0x4 with tx_byte_ready = 0 → tx_byte_valid = 1, tx_byte_data = 0x41. Raise ready → bytes 0x41 then 0x42 on consecutive cycles. STAT bit2 returns to 1.
- Push 17 bytes 0x00..0x10 on rx_byte_valid (FIFO_DEPTH = 16):
  - STAT = 0x23 (non-empty, full, overrun); a second STAT read = 0x03.
  - Reading 0x0 sixteen times returns 0x00..0x0F; a seventeenth read returns 0.
- Write CTRL 0x10, then push one RX byte → interrupt pulses exactly once. Pop it via 0x0; write a TX byte and drain it → a second pulse on TX empty.
- Hold bready = 0 for 5 cycles after a write to 0x4 → bvalid stays high. No second awready is given even with new awvalid/wvalid asserted.
- With RX full, push a byte in the same cycle as a 0x0 read pop → no overrun and 16 entries remain. Write CTRL 0x03 → STAT = 0x04.
